// File: rtl/wt_cache_controller_pkg.sv
// Shared widths, address field layout and FSM state encoding for the
// write-through direct-mapped cache controller.
package wt_cache_controller_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned TAG_W    = 3;
    localparam int unsigned INDEX_W  = 5;
    localparam int unsigned OFFSET_W = 2;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } cache_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/wt_cache_controller_cache_line_array.sv
// Valid/tag/data storage: one-word store port, full-line fill port and a
// combinational line read port. Only the valid bits are reset.
module cache_line_array
    import wt_cache_controller_pkg::*;
#(
    parameter int unsigned LINES          = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_line,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                fill_en,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_block
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES][WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // Tag/data are not cleared; a reset simply blocks any in-flight update.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (fill_en) begin
                tag_mem[fill_index] <= fill_tag;
                for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
                    data_mem[fill_index][w] <= fill_block[w*DATA_W +: DATA_W];
                end
            end else if (wr_en) begin
                data_mem[wr_index][wr_offset] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_line  = '0;
        rd_valid = valid[rd_index];
        rd_tag   = tag_mem[rd_index];
        for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
            rd_line[w*DATA_W +: DATA_W] = data_mem[rd_index][w];
        end
    end

endmodule

// File: rtl/wt_cache_controller.sv
// Direct-mapped write-through, no-write-allocate cache controller: IDLE
// serves hits, FILL fetches a block on a read miss, WRITE forwards stores.
module wt_cache_controller
    import wt_cache_controller_pkg::*;
#(
    parameter int unsigned LINES          = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_re,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               stall,
    output logic               mem_miss,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [BLOCK_W-1:0] mem_block,
    input  logic               mem_ready
);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    cache_addr_t        req;
    cache_addr_t        cap;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [BLOCK_W-1:0] rd_line;
    logic [DATA_W-1:0]  sel_word;
    logic               hit;
    logic               capture;
    logic               wr_en;
    logic               fill_en;

    assign req       = cache_addr_t'(cpu_addr);
    assign cap       = cache_addr_t'(addr_q);
    assign hit       = rd_valid && (rd_tag == req.tag);
    assign sel_word  = rd_line[{req.offset, 5'b0} +: DATA_W];
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    cache_line_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_lines (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_index   (req.index),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .wr_en      (wr_en),
        .wr_index   (req.index),
        .wr_offset  (req.offset),
        .wr_data    (cpu_wdata),
        .fill_en    (fill_en),
        .fill_index (cap.index),
        .fill_tag   (cap.tag),
        .fill_block (mem_block)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request address/data held for the whole memory transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_miss  = 1'b0;
        mem_we    = 1'b0;
        cpu_rdata = '0;
        capture   = 1'b0;
        wr_en     = 1'b0;
        fill_en   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_we) begin
                    capture   = 1'b1;
                    wr_en     = hit;
                    stall     = 1'b1;
                    state_nxt = WRITE;
                end else if (cpu_re) begin
                    if (hit) begin
                        cpu_rdata = sel_word;
                    end else begin
                        capture   = 1'b1;
                        stall     = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                mem_miss = 1'b1;
                stall    = 1'b1;
                if (mem_ready) begin
                    fill_en   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                stall  = ~mem_ready;
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wt_cache_controller.sv
// Scoreboard bench for wt_cache_controller: a flat memory model supplies
// expected load data and write-through traffic.
module tb_wt_cache_controller;
    import wt_cache_controller_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cpu_re;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               stall;
    logic               mem_miss;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [BLOCK_W-1:0] mem_block;
    logic               mem_ready;

    always #5 clk = ~clk;

    wt_cache_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_miss  (mem_miss),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_block (mem_block),
        .mem_ready (mem_ready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_model [1024];
    logic [31:0] rd_q [$];
    logic [41:0] wr_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] block_of(input logic [9:0] a);
        logic [127:0] b;
        logic [9:0]   wa;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            wa = {a[9:2], 2'(k)};
            b[32*k +: 32] = mem_model[wa];
        end
        return b;
    endfunction

    // Load; 'delay' is both the mem_ready latency and the expected number
    // of mem_miss cycles (0 means a hit is required).
    task automatic do_read(input logic [9:0] a, input int delay);
        int          cycles;
        int          misses;
        bit          done;
        logic [31:0] exp;
        @(negedge clk);
        cpu_re   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        rd_q.push_back(mem_model[a]);
        cycles = 0;
        misses = 0;
        done   = 1'b0;
        while (!done && cycles < 64) begin
            #1;
            if (!stall) begin
                exp = rd_q.pop_front();
                check("rdata", cpu_rdata, exp);
                check("miss_cycles", 32'(misses), 32'(delay));
                done = 1'b1;
            end else if (mem_miss) begin
                misses++;
                check("fill_addr", 32'(mem_addr), 32'(a));
                check("fill_no_we", 32'(mem_we), 32'd0);
                if (misses == delay) begin
                    mem_block = block_of(a);
                    mem_ready = 1'b1;
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            cycles++;
        end
        cpu_re = 1'b0;
        if (!done) check("read_timeout", 32'd0, 32'd1);
    endtask

    // Store through to memory; 'both' also raises cpu_re.
    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int delay, input bit both);
        int          cycles;
        int          wcnt;
        bit          done;
        logic [41:0] exp;
        @(negedge clk);
        cpu_we    = 1'b1;
        cpu_re    = both;
        cpu_addr  = a;
        cpu_wdata = d;
        wr_q.push_back({a, d});
        mem_model[a] = d;
        #1;
        check("st_idle_stall", 32'(stall), 32'd1);
        check("st_idle_no_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        cycles = 0;
        wcnt   = 0;
        done   = 1'b0;
        while (!done && cycles < 64) begin
            #1;
            if (mem_we) begin
                wcnt++;
                check("st_no_miss", 32'(mem_miss), 32'd0);
                exp = wr_q[0];
                check("wt_addr", 32'(mem_addr), 32'(exp[41:32]));
                check("wt_data", mem_wdata, exp[31:0]);
                if (wcnt < delay) begin
                    check("st_stall", 32'(stall), 32'd1);
                end else begin
                    void'(wr_q.pop_front());
                    mem_ready = 1'b1;
                    #1;
                    check("st_release", 32'(stall), 32'd0);
                    done = 1'b1;
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            cycles++;
        end
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        if (!done) check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_miss"}, 32'(mem_miss), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_rdata"}, cpu_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h5A00_0000 ^ 32'(i * 7);
        mem_model[4] = 32'h0000_0000;
        mem_model[5] = 32'h0000_0011;
        mem_model[6] = 32'h0000_0022;
        mem_model[7] = 32'h0000_0033;

        reset_n   = 1'b0;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_block = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_idle("reset");

        do_read(10'h004, 5);
        do_read(10'h006, 0);
        do_read(10'h007, 0);

        do_write(10'h005, 32'hDEADBEEF, 3, 1'b0);
        do_read(10'h005, 0);

        do_write(10'h204, 32'h12345678, 2, 1'b0);
        do_read(10'h004, 0);
        do_read(10'h204, 4);
        do_read(10'h005, 2);

        do_write(10'h010, 32'hCAFEF00D, 1, 1'b1);
        do_read(10'h010, 3);

        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check_idle("idle_ready");

        // Reset coinciding with mem_ready must abandon the fill.
        @(negedge clk);
        cpu_re   = 1'b1;
        cpu_addr = 10'h088;
        waited   = 0;
        #1;
        while (!mem_miss && waited < 16) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("abort_fill_seen", 32'(mem_miss), 32'd1);
        @(negedge clk);
        mem_block = block_of(10'h088);
        mem_ready = 1'b1;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        cpu_re    = 1'b0;
        check_idle("abort");
        do_read(10'h088, 3);
        do_read(10'h005, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wt_cache_controller.md
WT_CACHE_CONTROLLER -- requirements
Module: wt_cache_controller

Interface
REQ-001 Parameters: LINES, default 32, number of direct-mapped lines; WORDS_PER_LINE, default 4, 32-bit words per block.
REQ-002 Reset reset_n, synchronous, active-low; clock clk.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 cpu_re  input  1  CPU load request.
REQ-006 cpu_we  input  1  CPU store request; priority over cpu_re.
REQ-007 cpu_addr  input  10  word address: tag[9:7], index[6:2], offset[1:0].
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_rdata  output  32  load data; valid when cpu_re=1 and stall=0.
REQ-010 stall  output  1  freezes CPU while high.
REQ-011 mem_miss  output  1  block-fill request to data memory.
REQ-012 mem_we  output  1  write-through request to data memory.
REQ-013 mem_addr  output  10  memory word address, equal to the captured cpu_addr.
REQ-014 mem_wdata  output  32  write-through data, equal to the captured cpu_wdata.
REQ-015 mem_block  input  128  fill block; word k at bits [32k+31:32k].
REQ-016 mem_ready  input  1  memory completion pulse.

Function
REQ-017 FSM states are IDLE, FILL and WRITE.
REQ-018 hit = valid[index] and tag_array[index]==cpu_addr[9:7], evaluated combinationally in IDLE.
REQ-019 IDLE, cpu_we=1: capture address/data; on a hit, write cpu_wdata into the cached word at the same edge; go to WRITE. The policy is write-through, no-write-allocate.
REQ-020 IDLE, cpu_we=0, cpu_re=1, miss: capture address; go to FILL.
REQ-021 IDLE, read hit: cpu_rdata = selected word combinationally; stall=0; state stays IDLE.
REQ-022 FILL: mem_miss=1, mem_we=0. When mem_ready=1: write mem_block to line index, set tag and valid, return to IDLE. stall=1 throughout FILL.
REQ-023 WRITE: mem_we=1, mem_miss=0. stall = ~mem_ready. On mem_ready, return to IDLE; the CPU retires the store at that edge.
REQ-024 stall = 1 in IDLE when cpu_we=1, or when cpu_re=1 and there is a miss; stall = 0 in IDLE otherwise.
REQ-025 Read-miss latency: the request cycle, plus the FILL cycles up to and including mem_ready, plus one IDLE hit cycle that returns the data.
REQ-026 mem_miss and mem_we shall never both be 1, and each is 0 in IDLE.
REQ-027 mem_addr and mem_wdata hold their captured values for the whole of FILL/WRITE.
REQ-028 cpu_rdata = 0 whenever there is no read hit in IDLE.
REQ-029 mem_ready while in IDLE is ignored.
REQ-030 A fill overwrites any valid line at that index. No eviction traffic is generated, because memory is always current.

Reset
REQ-031 When reset_n=0 at a clock edge: state becomes IDLE, all valid bits clear, mem_miss=0, mem_we=0, cpu_rdata=0. Data and tag arrays are not cleared.
REQ-032 Reset during FILL or WRITE abandons the transaction. No line is updated even if mem_ready coincides with reset.

Structure
REQ-033 A shared package holds ADDR_W=10, DATA_W=32, BLOCK_W=128, the TAG/INDEX/OFFSET field widths and the state enum.
REQ-034 A single sub-module, cache_line_array, holds valid/tag/data storage. It provides a one-word write port, a full-line fill port and a combinational read port. The FSM and muxing live in the top module.

Verification
REQ-035 Reset, then read addr 0x004 with memory returning block {D3,D2,D1,D0} = {0x33,0x22,0x11,0x00} after a mem_ready delay of 5 -> mem_miss high for 5 cycles, mem_addr=0x004; the next cycle gives stall=0 and cpu_rdata=0x00.
REQ-036 Re-read 0x006 -> hit in one cycle, stall=0, cpu_rdata=0x22, mem_miss stays 0.
REQ-037 Store 0xDEADBEEF to 0x005 (hit) -> mem_we=1, mem_addr=0x005, mem_wdata=0xDEADBEEF until mem_ready; a following read of 0x005 hits with 0xDEADBEEF.
REQ-038 Store 0x12345678 to 0x204 (miss) -> write-through only; a following read of 0x204 misses and fills.
REQ-039 cpu_re=1 and cpu_we=1 together at 0x010 -> store path taken, mem_we=1, mem_miss=0.
REQ-040 reset_n=0 during FILL in the same cycle as mem_ready=1 -> IDLE, valid bit clear; a re-read of that address misses again.
